qpu_ifu_bht_bpu: RTL and testbench

//  Parametrised IFU branch predictor; next generation after the static lite-BPU. Adds a

---
 rtl/qpu_ifu_bht_bpu.sv | 85 ++++++++
 tb/tb_qpu_ifu_bht_bpu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/qpu_ifu_bht_bpu.sv
// rtl/qpu_ifu_bht_bpu.sv - IFU branch predictor: direct-mapped BHT of saturating counters with BTFN fallback
module qpu_ifu_bht_bpu #(
  parameter int PC_SIZE   = 32,
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PC_LSB    = 2,
  parameter int CNT_W     = 2,
  parameter int PRDT_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic               i_dec_bxx,
  input  logic [XLEN-1:0]    i_dec_bjp_imm,
  output logic               o_prdt_taken,
  output logic               o_prdt_hit,
  output logic [PC_SIZE-1:0] o_prdt_pc_add_op1,
  output logic [PC_SIZE-1:0] o_prdt_pc_add_op2,
  input  logic               i_upd_vld,
  input  logic [PC_SIZE-1:0] i_upd_pc,
  input  logic               i_upd_taken,
  input  logic               i_bht_clr
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             MODE_BHT = (PRDT_MODE != 0);

  logic [BHT_DEPTH-1:0] r_vld;
  logic [CNT_W-1:0]     r_cnt [BHT_DEPTH];

  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_upd_en;
  logic             w_clr_en;
  logic             w_unused_bits;

  assign w_ridx   = i_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign w_widx   = i_upd_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign w_upd_en = MODE_BHT & i_upd_vld;
  assign w_clr_en = MODE_BHT & i_bht_clr;

  // Bits outside the index field (and imm bits above the PC width) carry no meaning here.
  assign w_unused_bits = &{1'b0, i_upd_pc, i_dec_bjp_imm};

  // Lookup: valid entry supplies the counter MSB, otherwise the offset sign gives BTFN.
  always_comb begin
    o_prdt_hit   = MODE_BHT & i_dec_bxx & r_vld[w_ridx];
    o_prdt_taken = i_dec_bxx & (o_prdt_hit ? r_cnt[w_ridx][CNT_W-1] : i_dec_bjp_imm[XLEN-1]);
  end

  assign o_prdt_pc_add_op1 = i_pc;
  assign o_prdt_pc_add_op2 = i_dec_bjp_imm[PC_SIZE-1:0];

  // Next counter value: fresh entries start weak, trained entries saturate at both ends.
  always_comb begin
    w_cnt_cur = r_cnt[w_widx];
    w_cnt_nxt = w_cnt_cur;
    if (!r_vld[w_widx]) begin
      w_cnt_nxt = i_upd_taken ? CNT_WT : CNT_WNT;
    end else if (i_upd_taken) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_nxt = w_cnt_cur + CNT_W'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_nxt = w_cnt_cur - CNT_W'(1);
    end
  end

  // Table state: async reset, clear wins over a same-cycle update, clear keeps counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= '0;
    end else if (w_clr_en) begin
      r_vld <= '0;
    end else if (w_upd_en) begin
      r_vld[w_widx] <= 1'b1;
      r_cnt[w_widx] <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_qpu_ifu_bht_bpu.sv
// tb/tb_qpu_ifu_bht_bpu.sv - vector table plus scoreboard bench for qpu_ifu_bht_bpu
module tb_qpu_ifu_bht_bpu;

  localparam logic [31:0] IMM_N = 32'hFFFF_FFF0;
  localparam logic [31:0] IMM_P = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        bxx = 1'b0;
  logic [31:0] imm = '0;
  logic        upd_vld = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        bht_clr = 1'b0;

  logic        taken1, hit1, taken0, hit0;
  logic [31:0] op1_1, op2_1, op1_0, op2_0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        bxx;
    logic [31:0] imm;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        clr;
    logic        et;
    logic        eh;
  } vec_t;

  typedef struct {
    int          id;
    logic        taken;
    logic        hit;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        taken0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  qpu_ifu_bht_bpu #(.PRDT_MODE(1)) dut (
    .clk(clk), .rst(rst), .i_pc(pc), .i_dec_bxx(bxx), .i_dec_bjp_imm(imm),
    .o_prdt_taken(taken1), .o_prdt_hit(hit1),
    .o_prdt_pc_add_op1(op1_1), .o_prdt_pc_add_op2(op2_1),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken), .i_bht_clr(bht_clr)
  );

  qpu_ifu_bht_bpu #(.PRDT_MODE(0)) dut_static (
    .clk(clk), .rst(rst), .i_pc(pc), .i_dec_bxx(bxx), .i_dec_bjp_imm(imm),
    .o_prdt_taken(taken0), .o_prdt_hit(hit0),
    .o_prdt_pc_add_op1(op1_0), .o_prdt_pc_add_op2(op2_0),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken), .i_bht_clr(bht_clr)
  );

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] p, input logic b, input logic [31:0] im,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic clr, input logic et, input logic eh);
    vec_t v;
    v.pc = p; v.bxx = b; v.imm = im; v.uv = uv; v.upc = upc; v.ut = ut;
    v.clr = clr; v.et = et; v.eh = eh;
    vecs.push_back(v);
  endtask

  task automatic apply(input int id, input vec_t v);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    pc = v.pc; bxx = v.bxx; imm = v.imm;
    upd_vld = v.uv; upd_pc = v.upc; upd_taken = v.ut; bht_clr = v.clr;
    e.id = id; e.taken = v.et; e.hit = v.eh; e.op1 = v.pc; e.op2 = v.imm;
    e.taken0 = v.bxx & v.imm[31];
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty step %0d", id);
    end else begin
      g = sb.pop_front();
      chk("prdt_taken", g.id, {31'b0, taken1}, {31'b0, g.taken});
      chk("prdt_hit",   g.id, {31'b0, hit1},   {31'b0, g.hit});
      chk("op1",        g.id, op1_1,           g.op1);
      chk("op2",        g.id, op2_1,           g.op2);
      chk("static_hit", g.id, {31'b0, hit0},   32'd0);
      chk("static_taken", g.id, {31'b0, taken0}, {31'b0, g.taken0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //   pc            bxx imm    uv upd_pc       ut clr  exp_t exp_h
    add(32'h100,       1, IMM_N, 0, 32'h0,      0, 0,   1, 0);  // 0 reset: BTFN backward
    add(32'h100,       1, IMM_P, 1, 32'h100,    1, 0,   0, 0);  // 1 BTFN forward, train idx0 -> 2
    add(32'h100,       1, IMM_P, 1, 32'h100,    1, 0,   1, 1);  // 2 cnt 2 -> 3
    add(32'h100,       1, IMM_P, 1, 32'h100,    1, 0,   1, 1);  // 3 saturate 3
    add(32'h100,       1, IMM_P, 1, 32'h100,    1, 0,   1, 1);  // 4
    add(32'h100,       1, IMM_P, 1, 32'h100,    1, 0,   1, 1);  // 5
    add(32'h100,       1, IMM_P, 1, 32'h100,    0, 0,   1, 1);  // 6 cnt 3 -> 2
    add(32'h100,       1, IMM_P, 1, 32'h100,    0, 0,   1, 1);  // 7 cnt 2 -> 1
    add(32'h100,       1, IMM_N, 0, 32'h0,      0, 0,   0, 1);  // 8 cnt 1: not taken
    add(32'h100,       0, IMM_N, 0, 32'h0,      0, 0,   0, 0);  // 9 not a branch
    add(32'h200,       1, IMM_P, 1, 32'h200,    1, 0,   0, 1);  // 10 alias idx0, cnt 1 -> 2
    add(32'h100,       1, IMM_P, 0, 32'h0,      0, 0,   1, 1);  // 11 alias trained
    add(32'h104,       1, IMM_N, 0, 32'h0,      0, 0,   1, 0);  // 12 idx1 untrained
    add(32'h104,       1, IMM_P, 0, 32'h0,      0, 0,   0, 0);  // 13
    add(32'hFFFF_FF03, 1, IMM_P, 0, 32'h0,      0, 0,   1, 1);  // 14 outer bits ignored
    add(32'h100,       1, IMM_P, 1, 32'h14,     0, 0,   1, 1);  // 15 idx5 init weak NT (1)
    add(32'h14,        1, IMM_N, 1, 32'h14,     1, 0,   0, 1);  // 16 same-cycle: pre-update
    add(32'h14,        1, IMM_P, 0, 32'h0,      0, 0,   1, 1);  // 17 now cnt 2
    add(32'h14,        1, IMM_P, 1, 32'h104,    1, 1,   1, 1);  // 18 clear + update
    add(32'h14,        1, IMM_P, 0, 32'h0,      0, 0,   0, 0);  // 19 cleared
    add(32'h104,       1, IMM_P, 0, 32'h0,      0, 0,   0, 0);  // 20 update lost
    add(32'h100,       1, IMM_N, 1, 32'h100,    1, 0,   1, 0);  // 21 BTFN, retrain idx0 -> 2
    add(32'h100,       1, IMM_P, 0, 32'h0,      0, 0,   1, 1);  // 22 retrained

    #2;
    checks++;
    if (hit1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit: got %b expected 0", hit1);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset while entry idx0 is trained and being updated.
    @(posedge clk);
    #1;
    pc = 32'h100; bxx = 1'b1; imm = IMM_P; upd_vld = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; bht_clr = 1'b0;
    #2;
    chk("pre_rst_hit", 100, {31'b0, hit1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_hit",   101, {31'b0, hit1},   32'd0);
    chk("rst_taken", 102, {31'b0, taken1}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; upd_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_hit",   103, {31'b0, hit1},   32'd0);
    chk("post_rst_taken", 104, {31'b0, taken1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
